// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready push interface feeding the uart_tx_fifo input FIFO
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_din;
    logic              tx_vld;
    logic              tx_rdy;

    modport master (output tx_din, tx_vld, input tx_rdy);
    modport slave  (input tx_din, tx_vld, output tx_rdy);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with input FIFO; define UART_TX_PARITY_EN to add a parity bit
module uart_tx_fifo #(
    parameter int CLK_FRQ    = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_fifo_if.slave               tx,
    output logic                        tx_dout,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
    localparam int BPS_DIV = CLK_FRQ / BAUD;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int BW      = $clog2(BPS_DIV);

    if (BPS_DIV < 2 || DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("uart_tx_fifo: unsupported parameter set");

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_n;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_n;
    logic [BW-1:0]     cnt, cnt_n;
    logic [3:0]        idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              dout_n, bit_end, push, pop, empty;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign tx.tx_rdy = fifo_cnt != CW'(FIFO_DEPTH);
    assign push      = tx.tx_vld && tx.tx_rdy;
    assign empty     = fifo_cnt == '0;
    assign tx_busy   = state != IDLE;
    assign bit_end   = cnt == BW'(BPS_DIV - 1);

    // FIFO storage needs no reset; occupancy and pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx.tx_din;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FSM and serializer registers; the line output is registered so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            tx_dout <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            tx_dout <= dout_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    // next state: a pop loads the shifter and drives the start bit on the same edge
    always_comb begin
        state_n = state;
        cnt_n   = state != IDLE ? (bit_end ? '0 : cnt + 1'b1) : '0;
        idx_n   = idx;
        sh_n    = sh;
        dout_n  = tx_dout;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                sh_n    = mem[rd_ptr];
                state_n = START;
                dout_n  = 1'b0;
            end
            START: if (bit_end) begin
                state_n = DATA;
                idx_n   = '0;
                dout_n  = sh[0];
                sh_n    = sh >> 1;
            end
            DATA: if (bit_end) begin
                if (idx == 4'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    dout_n  = par;
`else
                    state_n = STOP;
                    idx_n   = '0;
                    dout_n  = 1'b1;
`endif
                end else begin
                    idx_n  = idx + 1'b1;
                    dout_n = sh[0];
                    sh_n   = sh >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_n = STOP;
                idx_n   = '0;
                dout_n  = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                if (idx == 4'(STOP_BITS - 1)) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_n    = mem[rd_ptr];
                        state_n = START;
                        dout_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                        dout_n  = 1'b1;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        if (pop) par_n = (^mem[rd_ptr]) ^ PARITY_ODD[0];
`endif
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO flow control and reset (UART_TX_PARITY_EN optional)
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = (10 + P) * 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dout_a, busy_a, dout_b, busy_b;
    logic [2:0] cnt_a, cnt_b;
    int         checks = 0;
    int         errors = 0;
    int         n;

    uart_tx_fifo_if #(.DATA_W(8)) ia ();
    uart_tx_fifo_if #(.DATA_W(8)) ib ();

    uart_tx_fifo #(.CLK_FRQ(50_000_000), .BAUD(5_000_000), .DATA_W(8), .STOP_BITS(1),
                   .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx(ia), .tx_dout(dout_a), .tx_busy(busy_a), .fifo_cnt(cnt_a));

    uart_tx_fifo #(.CLK_FRQ(50_000_000), .BAUD(5_000_000), .DATA_W(8), .STOP_BITS(2),
                   .FIFO_DEPTH(4), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx(ib), .tx_dout(dout_b), .tx_busy(busy_b), .fifo_cnt(cnt_b));

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // entered #1 after the edge that drives the start bit; leaves #1 after the frame's last edge
    task automatic frame(input bit b, input logic [7:0] d, input int sb, input int podd);
        logic [12:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (P == 1) bits[9] = (^d) ^ podd[0];
        nb = 9 + P + sb;
        for (int i = 0; i < nb * 10; i++) begin
            chk($sformatf("%s_%02h_dout_c%0d", b ? "b" : "a", d, i), b ? dout_b : dout_a, bits[i/10]);
            chk($sformatf("%s_%02h_busy_c%0d", b ? "b" : "a", d, i), b ? busy_b : busy_a, 1);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ia.tx_vld = 1'b0; ia.tx_din = '0;
        ib.tx_vld = 1'b0; ib.tx_din = '0;
        repeat (3) tick();
        chk("rst_dout", dout_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_rdy", ia.tx_rdy, 1);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_dout_b", dout_b, 1);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_dout", dout_a, 1);

        // single word, latency and bit pattern
        ia.tx_din = 8'h30; ia.tx_vld = 1'b1;
        tick();
        ia.tx_vld = 1'b0;
        chk("t2_cnt", cnt_a, 1);
        chk("t2_dout_pre", dout_a, 1);
        tick();
        chk("t2_cnt_pop", cnt_a, 0);
        frame(0, 8'h30, 1, 0);
        chk("t2_end_busy", busy_a, 0);
        chk("t2_end_dout", dout_a, 1);

        // three back-to-back words
        fork
            begin
                ia.tx_vld = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    ia.tx_din = 8'h31 + 8'(i);
                    chk($sformatf("t3_rdy%0d", i), ia.tx_rdy, 1);
                    tick();
                end
                ia.tx_vld = 1'b0;
                chk("t3_cnt", cnt_a, 2);
            end
            begin
                repeat (2) tick();
                for (int i = 0; i < 3; i++) frame(0, 8'h31 + 8'(i), 1, 0);
            end
        join
        chk("t3_end_busy", busy_a, 0);
        chk("t3_end_dout", dout_a, 1);

        // overfill: sixth word waits for the first pop
        fork
            begin
                ia.tx_vld = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    ia.tx_din = 8'h41 + 8'(i);
                    tick();
                end
                chk("t4_full_cnt", cnt_a, 4);
                chk("t4_full_rdy", ia.tx_rdy, 0);
                ia.tx_din = 8'h46;
                n = 0;
                while (!ia.tx_rdy && n < 300) begin
                    tick();
                    n++;
                end
                chk("t4_wait", n, FL - 3);
                tick();
                ia.tx_vld = 1'b0;
                chk("t4_cnt6", cnt_a, 4);
            end
            begin
                repeat (2) tick();
                for (int i = 0; i < 6; i++) frame(0, 8'h41 + 8'(i), 1, 0);
            end
        join
        chk("t4_end_busy", busy_a, 0);
        chk("t4_end_cnt", cnt_a, 0);

        // two stop bits, odd parity sense
        ib.tx_din = 8'h55; ib.tx_vld = 1'b1;
        tick();
        ib.tx_vld = 1'b0;
        tick();
        frame(1, 8'h55, 2, 1);
        chk("t5_end_busy", busy_b, 0);
        chk("t5_end_dout", dout_b, 1);

        // asynchronous reset in the middle of a frame with a word queued
        ia.tx_din = 8'h30; ia.tx_vld = 1'b1;
        tick();
        ia.tx_din = 8'h31;
        tick();
        ia.tx_vld = 1'b0;
        chk("rmf_pre_dout", dout_a, 0);
        chk("rmf_pre_cnt", cnt_a, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        chk("rmf_dout", dout_a, 1);
        chk("rmf_busy", busy_a, 0);
        chk("rmf_cnt", cnt_a, 0);
        chk("rmf_rdy", ia.tx_rdy, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            chk($sformatf("rmf_quiet_c%0d", i), {busy_a, dout_a}, 2'b01);
        end
        chk("rmf_end_cnt", cnt_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a small input FIFO and a valid/ready handshake. It replaces fixed 8N1, key-triggered byte sending with configurable data width, stop bits, optional parity and back-to-back framing. It sits between application logic, such as the key/command generators, and the serial line toward the wifi module.

Parameters:
CLK_FRQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate; bit period BPS_DIV = CLK_FRQ/BAUD cycles (integer division, must be >= 2).
DATA_W, 8, data bits per frame (5..9).
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_DEPTH, 4, FIFO entries (power of 2, >= 2).
PARITY_ODD, 0, parity sense, used only with UART_TX_PARITY_EN: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset.
tx_din  input  DATA_W  word to send.
tx_vld  input  1  tx_din valid.
tx_rdy  output  1  FIFO can accept; equals !full.
tx_dout  output  1  serial line, idle high.
tx_busy  output  1  frame in progress; high when state != IDLE.
fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- One clock, clk; reset rst_n asynchronous, active-low.
- Reset values: tx_dout=1, tx_busy=0, fifo_cnt=0, tx_rdy=1. FIFO pointers and bit/baud counters are cleared.
- Push: tx_vld && tx_rdy at a rising edge writes tx_din. tx_vld while tx_rdy=0 is ignored; the sender must hold the word.
- Simultaneous push and pop: fifo_cnt is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: if FIFO is non-empty, pop at the next edge, load the shift register, go to START and drive tx_dout=0 at that same edge.
- Latency: word pushed into an empty FIFO at edge N → tx_dout low from edge N+1.
- Bit timing: every bit lasts exactly BPS_DIV cycles. The baud counter runs only outside IDLE and restarts at 0 on each bit.
- DATA: sends DATA_W bits LSB first, then moves to PARITY (if enabled) or STOP.
- STOP: tx_dout=1 for STOP_BITS*BPS_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- tx_busy falls at the edge the FSM re-enters IDLE.
- FIFO is full with tx_vld high: no write. tx_rdy rises the cycle after the next pop.
- Reset mid-frame: tx_dout goes to 1 immediately (asynchronous). The partial frame and all FIFO contents are discarded.
- Frame length: (1 + DATA_W + P + STOP_BITS)*BPS_DIV cycles, where P = 1 with parity, 0 without.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state follows DATA for one bit period. The bit is the XOR of the data bits, inverted when PARITY_ODD=1.
- Undefined: no PARITY state, frame goes DATA→STOP, and PARITY_ODD is ignored.

Test Plan:
Test bench parameters: CLK_FRQ=50_000_000, BAUD=5_000_000 (BPS_DIV=10), DATA_W=8, FIFO_DEPTH=4, macro undefined unless stated.
1. Reset -> tx_dout=1, tx_busy=0, tx_rdy=1, fifo_cnt=0. Hold rst_n low mid-frame -> tx_dout=1 at once; after release fifo_cnt=0 and no further frame is sent.
2. Push 0x30 at edge N -> tx_dout low for cycles N+1..N+10, then bits 0,0,0,0,1,1,0,0 for 10 cycles each, stop high for 10 cycles. tx_busy high for 100 cycles.
3. Push 0x31, 0x32, 0x33 on consecutive cycles -> three contiguous 100-cycle frames, no idle gap, tx_rdy stays 1.
4. Push on 6 consecutive edges starting at N -> fifo_cnt=4 after edge N+4, so tx_rdy=0. The 6th word is held until the first frame ends, then accepted. All 6 words are sent in order.
5. STOP_BITS=2, push 0x55 -> stop high for 20 cycles, frame 110 cycles.
6. Macro defined, push 0x31 -> parity bit 1 when PARITY_ODD=0, 0 when PARITY_ODD=1. Frame is 110 cycles; without the macro it is 100.
